// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage PC sequencing with redirect drain and instruction-memory watchdog
module fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              load_use,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic              stall,
  output logic              jump_cs,
  output logic [ADDR_W-1:0] Next_pc,
  output logic              if_valid,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              redir;
  logic [ADDR_W-1:0] tgt;
  assign mem_err = err_q;
  // Next state and PC controls; the EX branch outranks the ID jump, and a busy memory defers the redirect
  always_comb begin
    redir       = br_taken | jump_req;
    tgt         = br_taken ? br_target : jump_target;
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    imem_req    = 1'b0;
    stall       = 1'b0;
    jump_cs     = 1'b0;
    Next_pc     = '0;
    if_valid    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state_q)
      BOOT: begin
        jump_cs     = 1'b1;
        Next_pc     = RESET_PC;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = FETCH;
      end
      FETCH: begin
        imem_req    = 1'b1;
        flush_if_id = redir;
        flush_id_ex = br_taken;
        jump_cs     = redir & imem_ready;
        Next_pc     = (redir & imem_ready) ? tgt : '0;
        stall       = ~imem_ready | (~redir & load_use);
        if_valid    = ~redir & ~load_use & imem_ready;
        pend_d      = (redir & ~imem_ready) ? tgt : pend_q;
        state_d     = (redir & ~imem_ready) ? DRAIN : FETCH;
      end
      DRAIN: begin
        imem_req    = 1'b1;
        flush_if_id = br_taken;
        flush_id_ex = br_taken;
        pend_d      = br_taken ? br_target : pend_q;
        stall       = ~imem_ready;
        jump_cs     = imem_ready;
        Next_pc     = imem_ready ? (br_taken ? br_target : pend_q) : '0;
        state_d     = imem_ready ? FETCH : DRAIN;
      end
      default: stall = 1'b1;
    endcase
    if (imem_req) begin
      cnt_d = imem_ready ? '0 : cnt_q + 1'b1;
      if (!imem_ready && cnt_q == CW'(TIMEOUT)) begin
        err_d   = 1'b1;
        state_d = HALT;
      end
    end
    if (rst) begin
      imem_req    = 1'b0;
      stall       = 1'b1;
      jump_cs     = 1'b0;
      Next_pc     = '0;
      if_valid    = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end
  // State, pending redirect target, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule
